// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind uart_rx. Each rising edge of uart_ready is one write.
// It has a first-word-fall-through read port, occupancy outputs and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          uart_data,
  input  logic                uart_ready,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ready_q;
  logic                  overflow_q, overflow_d;

  logic wr_evt;
  logic pop;
  logic push;
  logic ovf_set;
  logic is_full;
  logic is_empty;

  always_comb begin
    is_full    = (count_q == CNT_FULL);
    is_empty   = (count_q == '0);
    wr_evt     = uart_ready & ~ready_q;
    pop        = rd_en & ~is_empty;
    // A pop on the same edge frees the slot that a write into a full FIFO needs.
    push       = wr_evt & (~is_full | pop);
    ovf_set    = wr_evt & is_full & ~pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end
  end

  // ready_q resets high so that a ready level already present at release is not taken as a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= uart_ready;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= uart_data;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = ~is_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. A table of per-cycle vectors is followed by
// hand-written sequences for the fill, overflow, wrap and reset corner cases.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] uartData = 8'h00;
  logic       uartReady = 1'b0;
  logic       rdEn = 1'b0;
  logic       ovfClr = 1'b0;
  logic [7:0] rdData;
  logic       rdValid;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ready;
    logic [7:0] data;
    logic       rdEn;
    logic       ovfClr;
    logic [4:0] expCount;
    logic       expValid;
    logic       expFull;
    logic       expOvf;
    logic [7:0] expData;
    logic       chkData;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] model[$];

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_data  (uartData),
    .uart_ready (uartReady),
    .rd_en      (rdEn),
    .rd_data    (rdData),
    .rd_valid   (rdValid),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovfClr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] d, input logic e, input logic c);
    uartReady = r;
    uartData  = d;
    rdEn      = e;
    ovfClr    = c;
    step();
  endtask

  task automatic addVec(input logic r, input logic [7:0] d, input logic e, input logic c,
                        input logic [4:0] n, input logic v, input logic f, input logic o,
                        input logic [7:0] x, input logic k);
    vec_t t;
    t.ready = r; t.data = d; t.rdEn = e; t.ovfClr = c;
    t.expCount = n; t.expValid = v; t.expFull = f; t.expOvf = o;
    t.expData = x; t.chkData = k;
    vecs.push_back(t);
  endtask

  task automatic writeByte(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, 1'b0);
    applyStimulus(1'b0, b, 1'b0, 1'b0);
  endtask

  task automatic popByte(input logic [7:0] expected, input string name);
    checkOutput({name, " valid"}, 32'(rdValid), 32'd1);
    checkOutput({name, " data"}, 32'(rdData), 32'(expected));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic checkFlags(input string name, input logic [4:0] n, input logic v,
                            input logic f, input logic o);
    checkOutput({name, " count"}, 32'(count), 32'(n));
    checkOutput({name, " valid"}, 32'(rdValid), 32'(v));
    checkOutput({name, " full"}, 32'(full), 32'(f));
    checkOutput({name, " ovf"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] head;

    // Three spaced pulses, then three pops and one pop while empty.
    addVec(1, 8'h41, 0, 0, 1, 1, 0, 0, 8'h41, 1);
    for (int i = 0; i < 4; i++) addVec(0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h41, 1);
    addVec(1, 8'h42, 0, 0, 2, 1, 0, 0, 8'h41, 1);
    for (int i = 0; i < 4; i++) addVec(0, 8'h00, 0, 0, 2, 1, 0, 0, 8'h41, 1);
    addVec(1, 8'h43, 0, 0, 3, 1, 0, 0, 8'h41, 1);
    for (int i = 0; i < 4; i++) addVec(0, 8'h00, 0, 0, 3, 1, 0, 0, 8'h41, 1);
    addVec(0, 8'h00, 1, 0, 2, 1, 0, 0, 8'h42, 1);
    addVec(0, 8'h00, 1, 0, 1, 1, 0, 0, 8'h43, 1);
    addVec(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0);
    addVec(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0);
    // A ready level held for 20 cycles is a single write.
    for (int i = 0; i < 20; i++) addVec(1, 8'h55, 0, 0, 1, 1, 0, 0, 8'h55, 1);
    addVec(1, 8'h55, 1, 0, 0, 0, 0, 0, 8'h00, 0);
    addVec(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    // A write with rd_en while empty stores the byte and ignores the pop.
    addVec(1, 8'h99, 1, 0, 1, 1, 0, 0, 8'h99, 1);
    addVec(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0);

    $display("[TB] reset");
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checkFlags("reset", 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] vector table, %0d entries", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ready, vecs[i].data, vecs[i].rdEn, vecs[i].ovfClr);
      checkFlags($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expValid,
                 vecs[i].expFull, vecs[i].expOvf);
      if (vecs[i].chkData) begin
        checkOutput($sformatf("vec%0d data", i), 32'(rdData), 32'(vecs[i].expData));
      end
    end

    $display("[TB] fill and overflow");
    for (int i = 0; i < 16; i++) writeByte(8'(i));
    checkFlags("t3 filled", 5'd16, 1'b1, 1'b1, 1'b0);
    writeByte(8'hAA);
    checkFlags("t3 ovf", 5'd16, 1'b1, 1'b1, 1'b1);
    checkOutput("t3 head", 32'(rdData), 32'h00);
    for (int i = 0; i < 16; i++) popByte(8'(i), $sformatf("t3 drain%0d", i));
    checkFlags("t3 drained", 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t3 ovf clr", 32'(overflow), 32'd0);

    $display("[TB] overflow set wins over clear, then write+pop while full");
    for (int i = 0; i < 16; i++) writeByte(8'(8'h10 + i));
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
    checkFlags("setclr", 5'd16, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("setclr cleared", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkFlags("t4 wr+pop", 5'd16, 1'b1, 1'b1, 1'b0);
    checkOutput("t4 head", 32'(rdData), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) popByte(8'(8'h10 + i), $sformatf("t4 drain%0d", i));
    popByte(8'h77, "t4 last");
    checkFlags("t4 drained", 5'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] interleaved writes and pops across pointer wrap");
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 7 + 3);
      writeByte(b);
      model.push_back(b);
      if ((i % 3) != 0) begin
        head = model.pop_front();
        popByte(head, $sformatf("t5 pop%0d", i));
      end
      checkOutput($sformatf("t5 count%0d", i), 32'(count), 32'(model.size()));
      checkOutput($sformatf("t5 bound%0d", i), 32'(count <= 5'd16), 32'd1);
    end
    while (model.size() > 0) begin
      head = model.pop_front();
      popByte(head, "t5 tail");
    end
    checkFlags("t5 empty", 5'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-operation with ready held high");
    for (int i = 0; i < 4; i++) writeByte(8'(8'h60 + i));
    applyStimulus(1'b1, 8'h64, 1'b0, 1'b0);
    checkOutput("t6 count5", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    checkFlags("t6 in reset", 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h65, 1'b0, 1'b0);
      checkFlags($sformatf("t6 held%0d", i), 5'd0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h65, 1'b0, 1'b0);
    checkOutput("t6 fall", 32'(count), 32'd0);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    checkFlags("t6 rise", 5'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6 data", 32'(rdData), 32'h66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
